// File: rtl/bus_sequencer.sv
// Hardwired control FSM for the 16-bit single-bus datapath.
// Moore strobe decode; mdr_latch also follows mem_ready during read waits.
module bus_sequencer #(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir,
  input  logic [2:0]  psw,
  input  logic        mem_ready,
  output logic [7:0]  reg_enable,
  output logic [7:0]  reg_latch,
  output logic        pc_enable,
  output logic        pc_latch,
  output logic        pc_inc,
  output logic        mar_latch,
  output logic        mdr_latch,
  output logic        mdr_enable,
  output logic        ir_latch,
  output logic        y_latch,
  output logic        z_latch,
  output logic        z_enable,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  alu_control,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [3:0] {
    S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE,
    S_ALU1, S_ALU2, S_ALU3,
    S_LD1, S_LD2, S_LD3,
    S_ST1, S_ST2, S_ST3,
    S_BR1, S_HALT, S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] op;
  logic [2:0] rd, rs;
  logic [1:0] cond;
  logic       waiting, expired, taken;
  logic [2:0] alu_op;

  assign op   = ir[15:12];
  assign cond = ir[11:10];
  assign rd   = ir[10:8];
  assign rs   = ir[7:5];

  assign waiting = (state_q == S_FETCH1) ||
                   (state_q == S_LD2) ||
                   (state_q == S_ST3);
  assign expired = waiting && !mem_ready &&
                   (cnt_q == CNT_W'(WAIT_LIMIT - 1));

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      2'b00: taken = 1'b1;
      2'b01: taken = psw[0];
      2'b10: taken = psw[1];
      2'b11: taken = !psw[0];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    alu_op = 3'b000;
    unique case (op)
      4'd1:    alu_op = 3'b001;
      4'd2:    alu_op = 3'b011;
      4'd3:    alu_op = 3'b100;
      4'd4:    alu_op = 3'b101;
      4'd5:    alu_op = 3'b110;
      default: alu_op = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter idles at zero, so every wait state starts from a clean count.
  assign cnt_d = (waiting && !mem_ready) ? cnt_q + 1'b1 : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH0: state_d = S_FETCH1;
      S_FETCH1: begin
        if (mem_ready)    state_d = S_FETCH2;
        else if (expired) state_d = S_FAULT;
      end
      S_FETCH2: state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          op < 4'd6:   state_d = S_ALU1;
          op == 4'd6:  state_d = S_LD1;
          op == 4'd7:  state_d = S_ST1;
          op == 4'd8:  state_d = taken ? S_BR1 : S_FETCH0;
          op == 4'd15: state_d = S_HALT;
          default:     state_d = S_FETCH0;
        endcase
      end
      S_ALU1: state_d = S_ALU2;
      S_ALU2: state_d = S_ALU3;
      S_ALU3: state_d = S_FETCH0;
      S_LD1:  state_d = S_LD2;
      S_LD2: begin
        if (mem_ready)    state_d = S_LD3;
        else if (expired) state_d = S_FAULT;
      end
      S_LD3:  state_d = S_FETCH0;
      S_ST1:  state_d = S_ST2;
      S_ST2:  state_d = S_ST3;
      S_ST3: begin
        if (mem_ready)    state_d = S_FETCH0;
        else if (expired) state_d = S_FAULT;
      end
      S_BR1:   state_d = S_FETCH0;
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH0;
    endcase
  end

  always_comb begin
    reg_enable  = '0;
    reg_latch   = '0;
    pc_enable   = 1'b0;
    pc_latch    = 1'b0;
    pc_inc      = 1'b0;
    mar_latch   = 1'b0;
    mdr_latch   = 1'b0;
    mdr_enable  = 1'b0;
    ir_latch    = 1'b0;
    y_latch     = 1'b0;
    z_latch     = 1'b0;
    z_enable    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    alu_control = 3'b000;
    halted      = 1'b0;
    fault       = 1'b0;
    if (!reset) begin
      unique case (state_q)
        S_FETCH0: begin
          pc_enable = 1'b1;
          mar_latch = 1'b1;
        end
        S_FETCH1, S_LD2: begin
          mem_read  = 1'b1;
          mdr_latch = mem_ready;
        end
        S_FETCH2: begin
          mdr_enable = 1'b1;
          ir_latch   = 1'b1;
          pc_inc     = 1'b1;
        end
        S_ALU1: begin
          reg_enable = 8'b1 << rs;
          y_latch    = 1'b1;
        end
        S_ALU2: begin
          reg_enable  = 8'b1 << rd;
          z_latch     = 1'b1;
          alu_control = alu_op;
        end
        S_ALU3: begin
          z_enable  = 1'b1;
          reg_latch = 8'b1 << rd;
        end
        S_LD1, S_ST1: begin
          reg_enable = 8'b1 << rs;
          mar_latch  = 1'b1;
        end
        S_LD3: begin
          mdr_enable = 1'b1;
          reg_latch  = 8'b1 << rd;
        end
        S_ST2: begin
          reg_enable = 8'b1 << rd;
          mdr_latch  = 1'b1;
        end
        S_ST3: mem_write = 1'b1;
        S_BR1: begin
          reg_enable = 8'b1 << rs;
          pc_latch   = 1'b1;
        end
        S_HALT: halted = 1'b1;
        S_FAULT: begin
          halted = 1'b1;
          fault  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// Randomized bench for bus_sequencer: per-instruction strobe schedules
// derived from the instruction set rules, compared cycle by cycle.
module tb_bus_sequencer;

  localparam int WL = 4;

  localparam int P_FAULT = 0;
  localparam int P_HALT  = 1;
  localparam int P_MW    = 5;
  localparam int P_MR    = 6;
  localparam int P_ZE    = 7;
  localparam int P_ZL    = 8;
  localparam int P_YL    = 9;
  localparam int P_IRL   = 10;
  localparam int P_MDRE  = 11;
  localparam int P_MDRL  = 12;
  localparam int P_MARL  = 13;
  localparam int P_PCI   = 14;
  localparam int P_PCL   = 15;
  localparam int P_PCE   = 16;
  localparam int P_RL    = 17;
  localparam int P_RE    = 25;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ir;
  logic [2:0]  psw;
  logic        mem_ready;
  logic [7:0]  reg_enable, reg_latch;
  logic        pc_enable, pc_latch, pc_inc;
  logic        mar_latch, mdr_latch, mdr_enable;
  logic        ir_latch, y_latch, z_latch, z_enable;
  logic        mem_read, mem_write;
  logic [2:0]  alu_control;
  logic        halted, fault;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] alu_tab [6] = '{3'b000, 3'b001, 3'b011,
                              3'b100, 3'b101, 3'b110};

  bus_sequencer #(.WAIT_LIMIT(WL), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .ir(ir), .psw(psw),
    .mem_ready(mem_ready),
    .reg_enable(reg_enable), .reg_latch(reg_latch),
    .pc_enable(pc_enable), .pc_latch(pc_latch), .pc_inc(pc_inc),
    .mar_latch(mar_latch), .mdr_latch(mdr_latch),
    .mdr_enable(mdr_enable), .ir_latch(ir_latch),
    .y_latch(y_latch), .z_latch(z_latch), .z_enable(z_enable),
    .mem_read(mem_read), .mem_write(mem_write),
    .alu_control(alu_control), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  logic [32:0] obs;
  assign obs = {reg_enable, reg_latch, pc_enable, pc_latch, pc_inc,
                mar_latch, mdr_latch, mdr_enable, ir_latch, y_latch,
                z_latch, z_enable, mem_read, mem_write, alu_control,
                halted, fault};

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  always @(negedge clk)
    chk("onehot_drv",
        64'($onehot0({reg_enable, pc_enable, mdr_enable, z_enable})),
        64'd1);

  function automatic logic [32:0] b(input int p);
    logic [32:0] one;
    one = 33'd1;
    return one << p;
  endfunction

  function automatic logic [32:0] alu_v(input logic [2:0] c);
    logic [32:0] v;
    v = '0;
    v[4:2] = c;
    return v;
  endfunction

  task automatic cyc(input string tag, input logic [32:0] e,
                     input logic mr);
    mem_ready = mr;
    @(negedge clk);
    chk(tag, obs, e);
    @(posedge clk);
    #1;
  endtask

  // mem_ready is don't-care outside wait states, so it is randomized.
  task automatic idle(input string tag, input logic [32:0] e);
    cyc(tag, e, 1'($urandom));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) cyc("reset", '0, 1'($urandom));
    reset = 1'b0;
  endtask

  task automatic wait_phase(input string tag, input logic [32:0] base,
                            input logic rd_latch, input int nwait,
                            output logic faulted);
    faulted = 1'b0;
    if (nwait >= WL) begin
      repeat (WL) cyc(tag, base, 1'b0);
      faulted = 1'b1;
    end else begin
      repeat (nwait) cyc(tag, base, 1'b0);
      cyc(tag, rd_latch ? (base | b(P_MDRL)) : base, 1'b1);
    end
  endtask

  task automatic fault_tail();
    repeat (3) idle("fault_hold", b(P_HALT) | b(P_FAULT));
    do_reset(1);
  endtask

  task automatic run_instr(input logic [15:0] instr, input logic [2:0] p,
                           input int w1, input int w2);
    int op, rd, rs, cond;
    logic tk, f;
    op   = int'(instr[15:12]);
    cond = int'(instr[11:10]);
    rd   = int'(instr[10:8]);
    rs   = int'(instr[7:5]);
    ir   = instr;
    psw  = p;
    idle("fetch0", b(P_PCE) | b(P_MARL));
    wait_phase("fetch1", b(P_MR), 1'b1, w1, f);
    if (f) begin
      fault_tail();
      return;
    end
    idle("fetch2", b(P_MDRE) | b(P_IRL) | b(P_PCI));
    idle("decode", '0);
    if (op < 6) begin
      idle("alu_ex1", b(P_RE + rs) | b(P_YL));
      idle("alu_ex2", b(P_RE + rd) | b(P_ZL) | alu_v(alu_tab[op]));
      idle("alu_ex3", b(P_ZE) | b(P_RL + rd));
    end else if (op == 6) begin
      idle("ld_ex1", b(P_RE + rs) | b(P_MARL));
      wait_phase("ld_ex2", b(P_MR), 1'b1, w2, f);
      if (f) begin
        fault_tail();
        return;
      end
      idle("ld_ex3", b(P_MDRE) | b(P_RL + rd));
    end else if (op == 7) begin
      idle("st_ex1", b(P_RE + rs) | b(P_MARL));
      idle("st_ex2", b(P_RE + rd) | b(P_MDRL));
      wait_phase("st_ex3", b(P_MW), 1'b0, w2, f);
      if (f) fault_tail();
    end else if (op == 8) begin
      case (cond)
        0: tk = 1'b1;
        1: tk = p[0];
        2: tk = p[1];
        default: tk = !p[0];
      endcase
      if (tk) idle("br_ex1", b(P_RE + rs) | b(P_PCL));
    end else if (op == 15) begin
      repeat (20) idle("halt_hold", b(P_HALT));
      do_reset(2);
    end
  endtask

  function automatic int rand_wait();
    if ($urandom_range(0, 9) == 0) return WL;
    return int'($urandom_range(0, WL - 1));
  endfunction

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b1;
    ir        = '0;
    psw       = '0;
    #1;
    do_reset(2);

    run_instr(16'h1240, 3'b000, 0, 0);
    run_instr(16'h6320, 3'b000, 0, 3);
    run_instr(16'h8440, 3'b001, 0, 0);
    run_instr(16'h8440, 3'b000, 0, 0);
    run_instr(16'h7AE0, 3'b000, 0, WL - 1);
    run_instr(16'h0000, 3'b000, WL, 0);
    run_instr(16'h6320, 3'b000, 1, WL);

    // Reset mid-wait, then a full-budget wait must still succeed.
    ir = 16'h9000;
    idle("fetch0", b(P_PCE) | b(P_MARL));
    cyc("fetch1", b(P_MR), 1'b0);
    cyc("fetch1", b(P_MR), 1'b0);
    do_reset(1);
    run_instr(16'h9000, 3'b000, WL - 1, 0);

    for (int i = 0; i < 200; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 39) == 0) ? 4'd15
                                        : 4'($urandom_range(0, 14));
      run_instr({op, 12'($urandom)}, 3'($urandom),
                rand_wait(), rand_wait());
    end

    run_instr(16'hF000, 3'b000, 0, 0);
    run_instr(16'h5FFF, 3'b111, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_sequencer.md
Name: bus_sequencer

Overview:
Hardwired control FSM for the 16-bit single-bus datapath. Fetches instructions through MAR/MDR/IR and executes ALU, load, store, branch and halt instructions. It drives every enable and latch strobe on the shared DATA bus, including z_latch, which feeds the PSW Z_in condition-code update. It guarantees at most one bus driver per cycle.

Parameters:
WAIT_LIMIT, 255, maximum cycles spent waiting for mem_ready before entering FAULT
CNT_W, 8, width of the memory wait counter; must satisfy 2^CNT_W > WAIT_LIMIT

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high; the state machine enters FETCH0 and all strobes are 0
ir  in  16  IR register contents; [15:12] opcode, [11:10] branch condition, [10:8] Rd, [7:5] Rs
psw  in  3  PSW low bits; [0]=Z, [1]=N
mem_ready  in  1  memory completion for the current mem_read or mem_write
reg_enable  out  8  one-hot GPR bus-drive enable
reg_latch  out  8  one-hot GPR latch from bus
pc_enable / pc_latch / pc_inc  out  1 each  PC drive, PC load, PC increment
mar_latch / mdr_latch / mdr_enable  out  1 each  MAR load, MDR load, MDR drive
ir_latch / y_latch / z_latch / z_enable  out  1 each  IR load, Y load, Z load (also PSW Z_in), Z drive
mem_read / mem_write  out  1 each  memory request, held high until mem_ready
alu_control  out  3  ALU operation select
halted  out  1  high in HALT or FAULT
fault  out  1  high in FAULT only

Behaviour:
- All outputs are registered-free Moore decodes of the state, except mdr_latch during a read wait.
- Reset value of every output is 0, and alu_control is 000. Reset has priority in every state, including mid-wait and HALT/FAULT, and clears the wait counter.
- Fetch sequence:
  - FETCH0: pc_enable, mar_latch.
  - FETCH1: mem_read=1; when mem_ready=1, mdr_latch=1 in the same cycle and next state is FETCH2.
  - FETCH2: mdr_enable, ir_latch, pc_inc.
  - DECODE: one idle cycle; all strobes 0.
- Opcodes 0-5 (ALU):
  - EX1: reg_enable[Rs], y_latch.
  - EX2: reg_enable[Rd], z_latch, alu_control = ADD 000, SUB 001, AND 011, OR 100, XOR 101, NOT 110 for opcodes 0-5 respectively.
  - EX3: z_enable, reg_latch[Rd]; then FETCH0.
- Opcode 6, LOAD Rd <- mem[Rs]:
  - EX1: reg_enable[Rs], mar_latch.
  - EX2: mem_read until mem_ready, with mdr_latch on mem_ready.
  - EX3: mdr_enable, reg_latch[Rd].
- Opcode 7, STORE mem[Rs] <- Rd:
  - EX1: reg_enable[Rs], mar_latch.
  - EX2: reg_enable[Rd], mdr_latch.
  - EX3: mem_write until mem_ready.
- Opcode 8, BR to address in Rs:
  - Condition ir[11:10] selects 00 always, 01 Z=1, 10 N=1, 11 Z=0.
  - Taken: EX1 asserts reg_enable[Rs], pc_latch.
  - Not taken: return straight to FETCH0 from DECODE.
- Opcode 15: HALT; halted=1 and the FSM stays there until reset.
- Opcodes 9-14: NOP; DECODE returns to FETCH0 (4-cycle instruction with zero wait states).
- alu_control is 000 in every state except ALU EX2. 010 and 111 are never issued, so the PSW is touched only by opcodes 0-5.
- Wait counter:
  - Cleared on entry to each wait state and incremented every cycle mem_ready=0.
  - When it reaches WAIT_LIMIT with mem_ready still 0, next state is FAULT: halted=1, fault=1, all strobes 0, held until reset.
  - mem_ready arriving in the same cycle the counter reaches WAIT_LIMIT counts as success.
- mem_ready outside a wait state is ignored.
- Invariant: at most one of reg_enable bits, pc_enable, mdr_enable, z_enable is high in any cycle.
- Cycle counts with zero-wait memory (mem_ready already high):
  - ALU: 7 cycles
  - LOAD/STORE: 7 cycles
  - BR taken: 5 cycles; not taken: 4 cycles

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1 → FETCH0 strobes (pc_enable=1, mar_latch=1) on the first post-reset cycle; all other outputs 0.
- ir=0x1240 (SUB, Rd=2, Rs=2) with zero-wait memory → EX2 shows reg_enable=0x04, z_latch=1, alu_control=001; EX3 shows reg_latch=0x04; 7-cycle instruction.
- ir=0x6320 (LOAD Rd=3, Rs=1) with mem_ready delayed 3 cycles → mem_read high 4 cycles in EX2; mdr_latch pulses only with mem_ready; reg_latch=0x08 in EX3.
- ir=0x8440 (BR Z, Rs=2): psw=001 → reg_enable=0x04 and pc_latch=1; psw=000 → FETCH0 directly after DECODE with no pc_latch.
- mem_ready held 0 during FETCH1 with WAIT_LIMIT=4 → FAULT after 4 wait cycles (fault=1, halted=1); reset then restores FETCH0.
- ir=0xF000 → halted=1 held 20 cycles with all strobes 0; one-hot bus-driver invariant checked by assertion across all tests.
